// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the iterative multiply/divide unit.
//   md_op_e    : RV32M funct3 encodings
//   md_state_e : unit control states
//   is_div / is_rem / is_signed_a / is_signed_b : per-op decode
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

  // MUL is treated as unsigned: its low half is identical either way.
  function automatic logic is_signed_a(input md_op_e op);
    return (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return (op inside {OP_MULH, OP_DIV, OP_REM});
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (one bit per cycle).
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request, accepted in IDLE or DONE
//   op     : funct3 operation select
//   a, b   : rs1 / rs2 operands, captured on accept
//   flush  : abort any in-flight operation, result is kept
//   busy   : high while iterating (CALC) and correcting (FIXUP)
//   done   : one-cycle pulse, result valid
//   result : last completed result, held until the next done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W = DATA_WIDTH;

  md_state_e       state_q;
  md_op_e          op_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [W-1:0]    mcand_q;    // multiplicand or divisor magnitude
  logic [W-1:0]    hi_q;       // product high half / partial remainder
  logic [W-1:0]    lo_q;       // multiplier shifting out / dividend -> quotient
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]    result_q;
  logic            done_q;
  logic            busy_q;

  // Accept-side decode
  md_op_e          op_in;
  logic            sa_in, sb_in;
  logic [W-1:0]    a_mag, b_mag;
  logic            special;
  logic [W-1:0]    special_res;

  always_comb begin
    op_in       = md_op_e'(op);
    sa_in       = is_signed_a(op_in) & a[W-1];
    sb_in       = is_signed_b(op_in) & b[W-1];
    a_mag       = sa_in ? -a : a;
    b_mag       = sb_in ? -b : b;
    special     = 1'b0;
    special_res = '0;
    if (is_div(op_in)) begin
      if (b == '0) begin
        special     = 1'b1;
        special_res = is_rem(op_in) ? a : '1;
      end else if (is_signed_a(op_in) && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        special     = 1'b1;
        special_res = is_rem(op_in) ? '0 : a;
      end
    end
  end

  // One shared W+1 adder: add for shift-add multiply, subtract for the
  // restoring divide trial.
  logic            sub;
  logic [W:0]      add_x, add_y, add_sum;
  logic [W-1:0]    hi_d, lo_d;

  always_comb begin
    sub = is_div(op_q);
    if (sub) begin
      add_x = {hi_q, lo_q[W-1]};
      add_y = {1'b0, mcand_q};
    end else begin
      add_x = {1'b0, hi_q};
      add_y = lo_q[0] ? {1'b0, mcand_q} : '0;
    end
    add_sum = add_x + (add_y ^ {(W+1){sub}}) + {{W{1'b0}}, sub};
    if (sub) begin
      // Bit W set means the trial went negative: restore the shifted value.
      if (!add_sum[W]) begin
        hi_d = add_sum[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = add_x[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      // Shift {carry, sum, multiplier} right by one.
      hi_d = add_sum[W:1];
      lo_d = {add_sum[0], lo_q[W-1:1]};
    end
  end

  // Sign correction and output slice selection
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_fix = (sign_a_q ^ sign_b_q) ? -lo_q : lo_q;
    rem_fix  = sign_a_q ? -hi_q : hi_q;
    unique case (op_q)
      OP_MUL:                       fix_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            op_q     <= op_in;
            sign_a_q <= sa_in;
            sign_b_q <= sb_in;
            hi_q     <= '0;
            cnt_q    <= CNT_W'(W);
            if (is_div(op_in)) begin
              lo_q    <= a_mag;
              mcand_q <= b_mag;
            end else begin
              lo_q    <= b_mag;
              mcand_q <= a_mag;
            end
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive a request during the current cycle (t0); returns at t1 with
  // inputs scrambled so any late sampling of a/b/op shows up.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0; op = 3'b101; a = 32'hDEADBEEF; b = 32'h0;
  endtask

  // cyc0 = current cycle index relative to t0; bounded wait for done.
  task automatic wait_done(input string tag, input int cyc0, input int exp_lat,
                           input logic [31:0] exp_res);
    int cyc = cyc0;
    while (done !== 1'b1 && cyc < exp_lat + 8) begin
      step();
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, " result"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) step();
    chk("reset busy/done", {30'd0, busy, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    step();
    chk("idle busy/done", {30'd0, busy, done}, 32'd0);

    // MUL with cycle-exact busy/done profile
    issue(3'b000, 32'd7, 32'hFFFFFFFD);
    for (int k = 1; k <= 33; k++) begin
      chk($sformatf("mul busy t%0d", k), {30'd0, busy, done}, 32'd2);
      step();
    end
    chk("mul done t34", {30'd0, busy, done}, 32'd1);
    chk("mul result", result, 32'hFFFFFFEB);
    step();
    chk("mul t35 done low", {30'd0, busy, done}, 32'd0);
    chk("mul result held", result, 32'hFFFFFFEB);

    issue(3'b001, 32'h80000000, 32'h80000000);
    wait_done("mulh", 1, 34, 32'h40000000);
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mulhsu", 1, 34, 32'hFFFFFFFF);
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("mulhu", 1, 34, 32'hFFFFFFFE);

    issue(3'b100, 32'hFFFFFFF9, 32'd2);
    wait_done("div", 1, 34, 32'hFFFFFFFD);
    issue(3'b110, 32'hFFFFFFF9, 32'd2);
    wait_done("rem", 1, 34, 32'hFFFFFFFF);
    issue(3'b101, 32'd100, 32'd7);
    wait_done("divu", 1, 34, 32'd14);
    issue(3'b111, 32'd100, 32'd7);
    wait_done("remu", 1, 34, 32'd2);

    // Special cases complete one cycle after accept
    issue(3'b100, 32'd5, 32'd0);
    wait_done("div by 0", 1, 1, 32'hFFFFFFFF);
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div ovf", 1, 1, 32'h80000000);
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF);
    wait_done("rem ovf", 1, 1, 32'd0);
    issue(3'b111, 32'd5, 32'd0);
    wait_done("remu by 0", 1, 1, 32'd5);

    // Flush at t10 of a DIVU
    issue(3'b101, 32'd1000, 32'd3);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy/done t11", {30'd0, busy, done}, 32'd0);
    chk("flush result kept", result, 32'd5);
    issue(3'b000, 32'd3, 32'd4);
    wait_done("mul after flush", 1, 34, 32'd12);

    // Flush beats start in the same cycle
    step();
    op = 3'b000; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush over start busy/done", {30'd0, busy, done}, 32'd0);
    chk("flush over start result", result, 32'd12);

    // Reset at t5 of a MUL
    issue(3'b000, 32'd9, 32'd9);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst mid-op busy/done", {30'd0, busy, done}, 32'd0);
    chk("rst mid-op result", result, 32'd0);

    // Back-to-back: second op accepted in the DONE cycle of the first
    issue(3'b101, 32'd100, 32'd7);
    wait_done("b2b first", 1, 34, 32'd14);
    issue(3'b011, 32'hFFFFFFFF, 32'd2);
    wait_done("b2b second", 1, 34, 32'd1);

    // Start while busy is ignored
    issue(3'b000, 32'd5, 32'd6);
    repeat (3) step();
    op = 3'b100; a = 32'd1; b = 32'd0; start = 1'b1;
    step();
    start = 1'b0;
    wait_done("start while busy", 5, 34, 32'd30);
    step();
    chk("idle after done", {30'd0, busy, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
